meu_dff: RTL and testbench

//   Parameterizable D flip-flop / register stage with asynchronous active-low reset.

---
 rtl/meu_dff.sv | 56 +++++
 tb/tb_meu_dff.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/meu_dff.sv
`timescale 1ns/100ps
// meu_dff
//   Parameterizable D flip-flop / register stage with asynchronous active-low
//   reset. Used as the basic storage element of the program-counter and memory
//   datapath. With STAGES > 1 it becomes a delay line or synchronizer chain.
//
// Parameters
//   WIDTH      data width of entrada/saida (>= 1)
//   RESET_VAL  value loaded into every stage while reset is low (WIDTH bits)
//   STAGES     number of cascaded register stages (>= 1); latency in clk edges
//
// Ports (positional order is fixed: entrada, clk, reset, saida)
//   entrada  in   WIDTH  data input, sampled on the rising edge of clk
//   clk      in   1      clock, rising-edge active
//   reset    in   1      asynchronous, active-low; clears every stage to RESET_VAL
//   saida    out  WIDTH  last stage of the chain, driven straight from a flop
module meu_dff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               STAGES    = 1
) (
  input  logic [WIDTH-1:0] entrada,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] saida
);

  if (WIDTH < 1) begin : g_bad_width
    $error("meu_dff: WIDTH must be at least 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("meu_dff: STAGES must be at least 1");
  end

  logic [WIDTH-1:0] stage_p [STAGES];

  // Stage boundary: entrada -> stage_p[0] -> ... -> stage_p[STAGES-1].
  // The data chain itself is reset: a held reset must present RESET_VAL on
  // saida and discard everything in flight, without waiting for an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_p[i] <= RESET_VAL;
      end
    end else begin
      stage_p[0] <= entrada;
      for (int i = 1; i < STAGES; i++) begin
        stage_p[i] <= stage_p[i-1];
      end
    end
  end

  // Output boundary: no combinational path from entrada.
  assign saida = stage_p[STAGES-1];

endmodule

// File: tb/tb_meu_dff.sv
`timescale 1ns/100ps
// tb_meu_dff
//   Bench for meu_dff. Two instances share one clock: a default one
//   (WIDTH=1, STAGES=1, RESET_VAL=0) and a wide delay line (WIDTH=8, STAGES=3,
//   RESET_VAL=8'hA5). Directed steps cover reset, capture, async reset,
//   reset/edge collision, latency and hold; a randomized phase is then checked
//   against a queue-based reference model of "output = input sampled STAGES
//   edges ago since the last reset release, else RESET_VAL".
module tb_meu_dff;

  localparam logic [7:0] P_RST_VAL = 8'hA5;
  localparam int         P_STAGES  = 3;

  logic       clk;
  logic       d_rst, d_in, d_out;
  logic       p_rst;
  logic [7:0] p_in, p_out;

  int checks = 0;
  int errors = 0;

  meu_dff u_dflt (
    .entrada (d_in),
    .clk     (clk),
    .reset   (d_rst),
    .saida   (d_out)
  );

  meu_dff #(
    .WIDTH     (8),
    .RESET_VAL (P_RST_VAL),
    .STAGES    (P_STAGES)
  ) u_pipe (
    .entrada (p_in),
    .clk     (clk),
    .reset   (p_rst),
    .saida   (p_out)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Reference model: history of values accepted at rising edges since the
  // last reset release.
  logic       d_hist[$];
  logic [7:0] p_hist[$];

  always @(negedge d_rst) d_hist.delete();
  always @(negedge p_rst) p_hist.delete();

  always @(posedge clk) begin
    if (d_rst) begin
      d_hist.push_back(d_in);
      if (d_hist.size() > 1) void'(d_hist.pop_front());
    end
    if (p_rst) begin
      p_hist.push_back(p_in);
      if (p_hist.size() > P_STAGES) void'(p_hist.pop_front());
    end
  end

  function automatic logic d_exp();
    if (!d_rst) return 1'b0;
    if (d_hist.size() >= 1) return d_hist[$];
    return 1'b0;
  endfunction

  function automatic logic [7:0] p_exp();
    if (!p_rst) return P_RST_VAL;
    if (p_hist.size() >= P_STAGES) return p_hist[0];
    return P_RST_VAL;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #0.5;
  endtask

  initial begin
    logic [4:0] seq;
    d_rst = 1'b1;
    p_rst = 1'b1;
    d_in  = 1'b1;
    p_in  = 8'h00;

    // 1. Reset with entrada=1: output clears immediately, before any edge.
    #0.2;
    d_rst = 1'b0;
    p_rst = 1'b0;
    #0.2;
    chk("rst_imm_d", {7'd0, d_out}, 8'h00);
    chk("rst_imm_p", p_out, P_RST_VAL);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_d", {7'd0, d_out}, 8'h00);
      chk("rst_hold_p", p_out, P_RST_VAL);
    end
    @(negedge clk);
    d_rst = 1'b1;
    #0.3;
    chk("rel_no_edge_d", {7'd0, d_out}, 8'h00);
    tick();
    chk("rel_first_edge_d", {7'd0, d_out}, 8'h01);

    // 5. Wide delay line: entrada=3C at first edge N after release.
    @(negedge clk);
    p_rst = 1'b1;
    p_in  = 8'h3C;
    tick();
    chk("pipe_edge_n", p_out, P_RST_VAL);
    tick();
    chk("pipe_edge_n1", p_out, P_RST_VAL);
    tick();
    chk("pipe_edge_n2", p_out, 8'h3C);

    // 2. Capture 0,1,1,0,1 changed mid-cycle; never visible before the edge.
    seq = 5'b10110;  // bit 0 applied first
    for (int i = 0; i < 5; i++) begin
      logic prev;
      prev = d_out;
      @(negedge clk);
      d_in = seq[i];
      #0.4;
      chk("cap_not_early", {7'd0, d_out}, {7'd0, prev});
      tick();
      chk("cap_follow", {7'd0, d_out}, {7'd0, seq[i]});
    end

    // 3. Async reset between edges while saida=1, then release with entrada=1.
    @(negedge clk);
    #0.3;
    d_rst = 1'b0;
    #0.1;
    chk("async_mid", {7'd0, d_out}, 8'h00);
    @(negedge clk);
    d_rst = 1'b1;
    tick();
    chk("async_release", {7'd0, d_out}, 8'h01);

    // 4. Release coinciding with a rising edge: that edge still sees reset.
    // The nonblocking drive lands after the flop has evaluated the edge.
    @(negedge clk);
    d_rst = 1'b0;
    tick();
    chk("collide_pre", {7'd0, d_out}, 8'h00);
    @(posedge clk);
    d_rst <= 1'b1;
    #0.5;
    chk("collide_edge", {7'd0, d_out}, 8'h00);
    tick();
    chk("collide_next", {7'd0, d_out}, 8'h01);

    // 6. Hold entrada=1 for 10 cycles with glitches between edges.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d_in = 1'b0;
      #0.2;
      d_in = 1'b1;
      #0.3;
      chk("hold_glitch", {7'd0, d_out}, 8'h01);
      tick();
      chk("hold_edge", {7'd0, d_out}, 8'h01);
    end

    // Randomized phase against the reference model.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      d_in = 1'($urandom);
      p_in = 8'($urandom);
      if (!d_rst) d_rst = 1'b1;
      else if ($urandom_range(0, 19) == 0) d_rst = 1'b0;
      if (!p_rst) p_rst = ($urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 24) == 0) p_rst = 1'b0;
      #0.3;
      chk("rnd_mid_d", {7'd0, d_out}, {7'd0, d_exp()});
      chk("rnd_mid_p", p_out, p_exp());
      tick();
      chk("rnd_edge_d", {7'd0, d_out}, {7'd0, d_exp()});
      chk("rnd_edge_p", p_out, p_exp());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
